reg_file_mp: RTL and testbench

Multi-port, parametrised integer register file with same-cycle write-to-read bypass, hardwired-zero register option, and an integrated scoreboard tracking registers with an in-flight producer. Sits in the ID stage. Read ports feed operand fetch. Write ports are driven by the WB stage and any future additional retire paths. The scoreboard busy bits let the hazard unit stall on operands whose producer has not yet written back.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 93 +++++++++
 rtl/reg_file_mp.sv | 102 ++++++++++
 tb/tb_reg_file_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the multi-port register file.
//   - DEF_* : default parameter values for reg_file_mp and its sub-modules
//   - REG_ZERO : address of the hardwired-zero register
//   - addr_t / data_t : address and data types at the default widths
package reg_file_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_SIZE   = 32;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_NUM_WR     = 1;
    localparam int DEF_ZERO_REG   = 1;

    localparam int unsigned REG_ZERO = 32'd0;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_REG_SIZE-1:0]   data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per register marking an in-flight producer.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   rd_addr_i       per-read-port register address
//   wr_en_i         per-write-port enable (already stripped of zero-register writes)
//   wr_addr_i       per-write-port address
//   claim_i         set busy for claim_addr_i (already stripped of zero-register claims)
//   claim_addr_i    destination being claimed
//   flush_i         clear every busy bit, overriding any claim
//   rd_busy_o       busy and not being written back this cycle
//   busy_cnt_o      registered count of busy registers
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [NUM_WR-1:0]                   wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic                                claim_i,
    input  logic [ADDR_WIDTH-1:0]               claim_addr_i,
    input  logic                                flush_i,
    output logic [NUM_RD-1:0]                   rd_busy_o,
    output logic [ADDR_WIDTH:0]                 busy_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]    busy_r;
    logic [DEPTH-1:0]    busy_next_s;
    logic [ADDR_WIDTH:0] cnt_next_s;
    logic [ADDR_WIDTH:0] busy_cnt_r;
    logic [NUM_RD-1:0]   rd_hit_s;

    // Next busy vector: flush beats claim, claim beats a retiring write.
    always_comb begin
        busy_next_s = busy_r;
        if (flush_i) begin
            busy_next_s = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j]) begin
                    busy_next_s[wr_addr_i[j]] = 1'b0;
                end else begin
                    busy_next_s = busy_next_s;
                end
            end
            if (claim_i) begin
                busy_next_s[claim_addr_i] = 1'b1;
            end else begin
                busy_next_s = busy_next_s;
            end
        end
    end

    // Popcount of the next busy vector so the registered count tracks the bits exactly.
    always_comb begin
        cnt_next_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next_s = cnt_next_s + {{ADDR_WIDTH{1'b0}}, busy_next_s[k]};
        end
    end

    // Busy vector and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_next_s;
            busy_cnt_r <= cnt_next_s;
        end
    end

    // Operand busy lookup; a write-back in this cycle hides the busy bit (its data is bypassed).
    always_comb begin
        rd_hit_s  = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                rd_hit_s[i] = rd_hit_s[i] | (wr_en_i[j] & (wr_addr_i[j] == rd_addr_i[i]));
            end
            rd_busy_o[i] = busy_r[rd_addr_i[i]] & ~rd_hit_s[i];
        end
    end

    assign busy_cnt_o = busy_cnt_r;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-to-read bypass,
// optional hardwired-zero register and an operand-busy scoreboard.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   rd_addr_i       NUM_RD read addresses
//   rd_data_o       NUM_RD read data (combinational, bypassed)
//   rd_busy_o       NUM_RD operand-pending flags
//   wr_en_i         NUM_WR write enables
//   wr_addr_i       NUM_WR write addresses
//   wr_data_i       NUM_WR write data; highest port index wins on conflict
//   claim_i         mark claim_addr_i busy from the next cycle
//   claim_addr_i    destination register being claimed
//   flush_i         clear all busy bits at the next edge
//   busy_cnt_o      registered number of busy registers
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_SIZE   = DEF_REG_SIZE,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD-1:0][REG_SIZE-1:0]     rd_data_o,
    output logic [NUM_RD-1:0]                   rd_busy_o,
    input  logic [NUM_WR-1:0]                   wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [NUM_WR-1:0][REG_SIZE-1:0]     wr_data_i,
    input  logic                                claim_i,
    input  logic [ADDR_WIDTH-1:0]               claim_addr_i,
    input  logic                                flush_i,
    output logic [ADDR_WIDTH:0]                 busy_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [REG_SIZE-1:0] mem_r [DEPTH];
    logic [NUM_WR-1:0]   wr_en_q_s;
    logic                claim_q_s;

    // Writes and claims aimed at the hardwired-zero register are dropped here,
    // so neither the array, the bypass nor the scoreboard ever sees them.
    always_comb begin
        wr_en_q_s = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_en_q_s[j] = wr_en_i[j] & ~(ZERO_EN & (wr_addr_i[j] == ZERO_ADDR));
        end
    end

    assign claim_q_s = claim_i & ~(ZERO_EN & (claim_addr_i == ZERO_ADDR));

    // Register array; later ports in the loop overwrite earlier ones so the highest index wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_q_s[j]) begin
                    mem_r[wr_addr_i[j]] <= wr_data_i[j];
                end
            end
        end
    end

    // Read mux with same-cycle bypass, same highest-port-wins order as the array.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_o[i] = mem_r[rd_addr_i[i]];
            for (int j = 0; j < NUM_WR; j++) begin
                rd_data_o[i] = (wr_en_q_s[j] && (wr_addr_i[j] == rd_addr_i[i]))
                               ? wr_data_i[j] : rd_data_o[i];
            end
            rd_data_o[i] = (ZERO_EN && (rd_addr_i[i] == ZERO_ADDR)) ? '0 : rd_data_o[i];
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_addr_i    (rd_addr_i),
        .wr_en_i      (wr_en_q_s),
        .wr_addr_i    (wr_addr_i),
        .claim_i      (claim_q_s),
        .claim_addr_i (claim_addr_i),
        .flush_i      (flush_i),
        .rd_busy_o    (rd_busy_o),
        .busy_cnt_o   (busy_cnt_o)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [1:0][4:0]       rd_addr = '0;
    logic [1:0][31:0]      rd_data;
    logic [1:0]            rd_busy;
    logic [1:0]            wr_en = '0;
    logic [1:0][4:0]       wr_addr = '0;
    logic [1:0][31:0]      wr_data = '0;
    logic                  claim = 1'b0;
    logic [4:0]            claim_addr = '0;
    logic                  flush = 1'b0;
    logic [5:0]            busy_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  we;
        addr_t       wa0;
        data_t       wd0;
        addr_t       wa1;
        data_t       wd1;
        logic        claim;
        addr_t       ca;
        logic        flush;
        addr_t       ra0;
        addr_t       ra1;
        data_t       ed0;
        data_t       ed1;
        logic [1:0]  ebusy;
        logic [5:0]  ecnt;
    } vec_t;

    typedef struct {
        data_t       ed0;
        data_t       ed1;
        logic [1:0]  ebusy;
        logic [5:0]  ecnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    reg_file_mp #(
        .ADDR_WIDTH (5),
        .REG_SIZE   (32),
        .NUM_RD     (2),
        .NUM_WR     (2),
        .ZERO_REG   (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .claim_i      (claim),
        .claim_addr_i (claim_addr),
        .flush_i      (flush),
        .busy_cnt_o   (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] we, input addr_t wa0, input data_t wd0,
                                input addr_t wa1, input data_t wd1, input logic cl,
                                input addr_t ca, input logic fl, input addr_t ra0,
                                input addr_t ra1, input data_t ed0, input data_t ed1,
                                input logic [1:0] ebusy, input logic [5:0] ecnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.claim = cl; v.ca = ca; v.flush = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.ebusy = ebusy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        wr_en      = v.we;
        wr_addr[0] = v.wa0;
        wr_data[0] = v.wd0;
        wr_addr[1] = v.wa1;
        wr_data[1] = v.wd1;
        claim      = v.claim;
        claim_addr = v.ca;
        flush      = v.flush;
        rd_addr[0] = v.ra0;
        rd_addr[1] = v.ra1;
        e.ed0 = v.ed0; e.ed1 = v.ed1; e.ebusy = v.ebusy; e.ecnt = v.ecnt;
        exp_q.push_back(e);
    endtask

    task automatic check_cycle(input int idx);
        exp_t e;
        #2;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d rd_data0", idx), rd_data[0], e.ed0);
            chk($sformatf("v%0d rd_data1", idx), rd_data[1], e.ed1);
            chk($sformatf("v%0d rd_busy", idx), {30'd0, rd_busy}, {30'd0, e.ebusy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_cnt", idx), {26'd0, busy_cnt}, {26'd0, e.ecnt});
        end
    endtask

    initial begin
        // Reset state: every address reads 0 and nothing is busy.
        @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(31 - a);
            #1;
            chk($sformatf("reset rd%0d", a), rd_data[0] | rd_data[1], 32'd0);
        end
        chk("reset busy", {30'd0, rd_busy}, 32'd0);
        chk("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);

        // Reset asserted in the middle of a write and with a claim outstanding.
        @(negedge clk);
        rst = 1'b0;
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h0000_0011;
        claim = 1'b1; claim_addr = 5'd6;
        @(negedge clk);
        wr_en = 2'b00; claim = 1'b0;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
        #1;
        chk("pre-rst x5", rd_data[0], 32'h0000_0011);
        chk("pre-rst busy x6", {30'd0, rd_busy}, 32'd2);
        chk("pre-rst busy_cnt", {26'd0, busy_cnt}, 32'd1);
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
        #1;
        rst = 1'b1;
        #1;
        chk("in-rst busy_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("in-rst bypass x5", rd_data[0], 32'hDEAD_BEEF);
        chk("in-rst busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 2'b00;
        #1;
        chk("post-rst x5", rd_data[0], 32'd0);
        chk("post-rst busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("post-rst busy_cnt", {26'd0, busy_cnt}, 32'd0);

        //                we     wa0    wd0            wa1    wd1           cl    ca     fl    ra0    ra1    ed0            ed1            busy   cnt
        vecs.push_back(mk(2'b01, 5'd7,  32'h1234,      5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h1234,      32'h1234,      2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h1234,      32'h1234,      2'b00, 6'd0));
        vecs.push_back(mk(2'b11, 5'd3,  32'hAAAA,      5'd3,  32'h5555,     1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  32'h5555,      32'h5555,      2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h5555,      32'h1234,      2'b00, 6'd0));
        vecs.push_back(mk(2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'h0,         32'h0,         2'b00, 6'd1));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd7,  32'h0,         32'h1234,      2'b01, 6'd1));
        vecs.push_back(mk(2'b01, 5'd9,  32'h99,        5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h99,        32'h99,        2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h99,        32'h99,        2'b00, 6'd0));
        vecs.push_back(mk(2'b10, 5'd9,  32'h1,         5'd9,  32'h77,       1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'h77,        32'h77,        2'b00, 6'd1));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd3,  32'h77,        32'h5555,      2'b01, 6'd1));
        vecs.push_back(mk(2'b01, 5'd9,  32'h55,        5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'h55,        32'h55,        2'b00, 6'd1));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h55,        32'h55,        2'b11, 6'd1));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd9,  32'h0,         32'h55,        2'b10, 6'd2));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd1,  5'd2,  32'h0,         32'h0,         2'b01, 6'd3));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd2,  5'd3,  32'h0,         32'h5555,      2'b01, 6'd4));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd3,  5'd4,  32'h5555,      32'h0,         2'b01, 6'd0));
        vecs.push_back(mk(2'b01, 5'd20, 32'h1,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd4,  5'd20, 32'h0,         32'h1,         2'b00, 6'd0));
        vecs.push_back(mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd20, 5'd9,  32'h1,         32'h55,        2'b00, 6'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_cycle(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
